// File: rtl/boot_sram_ctrl_pkg.sv
// Shared definitions for the boot/program SRAM controller: register-select
// encodings, controller states, status bit positions and a counter sizing helper.
package boot_sram_ctrl_pkg;

  // Register select encodings carried on wr_sel (6 and 7 are ignored).
  localparam logic [2:0] SEL_ADDR_LO = 3'd0;
  localparam logic [2:0] SEL_ADDR_HI = 3'd1;
  localparam logic [2:0] SEL_DATA    = 3'd2;
  localparam logic [2:0] SEL_RD      = 3'd3;
  localparam logic [2:0] SEL_CTRL    = 3'd4;
  localparam logic [2:0] SEL_BOOT    = 3'd5;

  // Status word layout: {overrun, busy, run_mode}.
  localparam int STAT_W    = 3;
  localparam int STAT_RUN  = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_OVR  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_HOLD   = 3'd2,
    ST_RD     = 3'd3,
    ST_SWITCH = 3'd4,
    ST_RUN    = 3'd5
  } state_e;

  // Width of the phase counter: must hold both the wait-state reload and the
  // switch-delay reload. Never returns less than one bit.
  function automatic int cnt_width(input int wait_states, input int switch_dly);
    int max_v;
    max_v = (wait_states > switch_dly) ? wait_states : switch_dly;
    return (max_v < 1) ? 1 : $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/boot_sram_ctrl_if.sv
// CPU-side register bus of the boot SRAM controller: write strobe, select and
// data from the CPU, plus the read-back registers and status returned to it.
interface boot_sram_ctrl_if
  import boot_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              wr_en;
  logic [2:0]        wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [STAT_W-1:0] status;

  modport master (
    output wr_en, wr_sel, wr_data,
    input  rd_addr_q, rd_data_q, status
  );

  modport slave (
    input  wr_en, wr_sel, wr_data,
    output rd_addr_q, rd_data_q, status
  );
endinterface

// File: rtl/boot_sram_ctrl_phase_counter.sv
// Load/decrement down-counter with a zero flag. One instance times both the
// SRAM wait states and the LOAD->RUN switch delay, since they never overlap.
module sram_phase_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q;

  // Counter register: load wins over decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/boot_sram_ctrl.sv
// Boot/program SRAM controller. In LOAD mode the bootloader (fetched from ROM)
// fills external SRAM through memory-mapped registers; after a BOOT request and
// a short idle delay the controller enters RUN and the CPU fetches from SRAM.
module boot_sram_ctrl
  import boot_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int PC_W        = 16,  // must be <= ADDR_W
  parameter int WAIT_STATES = 1,
  parameter int SWITCH_DLY  = 2    // must be >= 1
) (
  input  logic              clk,
  input  logic              rst,
  boot_sram_ctrl_if.slave   bus,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] rom_instr,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic              sram_oen
);
  localparam int               CNT_W     = cnt_width(WAIT_STATES, SWITCH_DLY);
  localparam logic [CNT_W-1:0] WAIT_LD   = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] SWITCH_LD = CNT_W'(SWITCH_DLY - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, acc_addr_q;
  logic [DATA_W-1:0] rd_data_q, dq_o_q;
  logic              auto_inc_q, overrun_q, boot_pend_q;

  logic              reg_wr_s, busy_s, acc_req_s, boot_req_s, boot_go_s;
  logic              accept_s, access_end_s, rd_sample_s;
  logic              cnt_load_s, cnt_dec_s, cnt_zero_s;
  logic [CNT_W-1:0]  cnt_val_s;
  logic              cen_s, wen_s, oen_s, dq_oe_s;
  logic [ADDR_W-1:0] addr_lo_wr_s, addr_hi_wr_s;

  // Writes are honoured in every LOAD state; RUN ignores the register bus.
  assign reg_wr_s   = bus.wr_en && (state_q != ST_RUN);
  assign busy_s     = (state_q == ST_WR) || (state_q == ST_HOLD) ||
                      (state_q == ST_RD) || (state_q == ST_SWITCH);
  assign acc_req_s  = reg_wr_s && ((bus.wr_sel == SEL_DATA) || (bus.wr_sel == SEL_RD));
  assign boot_req_s = reg_wr_s && (bus.wr_sel == SEL_BOOT);
  assign boot_go_s  = boot_pend_q || boot_req_s;

  // Address register merges; the high half only exists when ADDR_W > DATA_W.
  if (ADDR_W > DATA_W) begin : g_addr_hi
    assign addr_lo_wr_s = {addr_q[ADDR_W-1:DATA_W], bus.wr_data};
    assign addr_hi_wr_s = {bus.wr_data[ADDR_W-DATA_W-1:0], addr_q[DATA_W-1:0]};
  end else begin : g_addr_no_hi
    assign addr_lo_wr_s = bus.wr_data[ADDR_W-1:0];
    assign addr_hi_wr_s = addr_q;
  end

  sram_phase_counter #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_val_s),
    .dec_i      (cnt_dec_s),
    .zero_o     (cnt_zero_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, phase-counter control and SRAM strobe decode.
  always_comb begin
    state_d      = state_q;
    cnt_load_s   = 1'b0;
    cnt_val_s    = WAIT_LD;
    cnt_dec_s    = 1'b0;
    accept_s     = 1'b0;
    access_end_s = 1'b0;
    rd_sample_s  = 1'b0;
    cen_s        = 1'b1;
    wen_s        = 1'b1;
    oen_s        = 1'b1;
    dq_oe_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc_req_s) begin
          accept_s   = 1'b1;
          cnt_load_s = 1'b1;
          state_d    = (bus.wr_sel == SEL_DATA) ? ST_WR : ST_RD;
        end else if (boot_req_s) begin
          cnt_load_s = 1'b1;
          cnt_val_s  = SWITCH_LD;
          state_d    = ST_SWITCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        cen_s   = 1'b0;
        wen_s   = 1'b0;
        dq_oe_s = 1'b1;
        if (cnt_zero_s) begin
          state_d = ST_HOLD;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_HOLD: begin
        cen_s        = 1'b0;
        dq_oe_s      = 1'b1;
        access_end_s = 1'b1;
        if (boot_go_s) begin
          cnt_load_s = 1'b1;
          cnt_val_s  = SWITCH_LD;
          state_d    = ST_SWITCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        cen_s = 1'b0;
        oen_s = 1'b0;
        if (cnt_zero_s) begin
          rd_sample_s  = 1'b1;
          access_end_s = 1'b1;
          if (boot_go_s) begin
            cnt_load_s = 1'b1;
            cnt_val_s  = SWITCH_LD;
            state_d    = ST_SWITCH;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_SWITCH: begin
        if (cnt_zero_s) begin
          state_d = ST_RUN;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_RUN: begin
        cen_s = 1'b0;
        oen_s = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: address/control registers, access latches, read-back, flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      acc_addr_q  <= '0;
      rd_data_q   <= '0;
      dq_o_q      <= '0;
      auto_inc_q  <= 1'b0;
      overrun_q   <= 1'b0;
      boot_pend_q <= 1'b0;
    end else begin
      // The access address is frozen at acceptance so later addr writes
      // only steer the next access.
      if (accept_s) begin
        acc_addr_q <= addr_q;
      end
      if (accept_s && (bus.wr_sel == SEL_DATA)) begin
        dq_o_q <= bus.wr_data;
      end
      if (reg_wr_s && (bus.wr_sel == SEL_ADDR_LO)) begin
        addr_q <= addr_lo_wr_s;
      end else if (reg_wr_s && (bus.wr_sel == SEL_ADDR_HI)) begin
        addr_q <= addr_hi_wr_s;
      end else if (access_end_s && auto_inc_q) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      if (rd_sample_s) begin
        rd_data_q <= sram_dq_i;
      end
      if (reg_wr_s && (bus.wr_sel == SEL_CTRL)) begin
        auto_inc_q <= bus.wr_data[0];
      end
      if (acc_req_s && busy_s) begin
        overrun_q <= 1'b1;
      end else if (reg_wr_s && (bus.wr_sel == SEL_CTRL) && bus.wr_data[1]) begin
        overrun_q <= 1'b0;
      end
      if (state_d == ST_SWITCH) begin
        boot_pend_q <= 1'b0;
      end else if (boot_req_s && busy_s) begin
        boot_pend_q <= 1'b1;
      end
    end
  end

  assign bus.rd_addr_q = addr_q;
  assign bus.rd_data_q = rd_data_q;
  assign bus.status    = {overrun_q, busy_s, (state_q == ST_RUN)};

  assign instr      = (state_q == ST_RUN) ? sram_dq_i : rom_instr;
  assign sram_addr  = (state_q == ST_RUN) ? ADDR_W'(pc) : acc_addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_s;
  assign sram_cen   = cen_s;
  assign sram_wen   = wen_s;
  assign sram_oen   = oen_s;
endmodule

// File: tb/tb_boot_sram_ctrl.sv
// Directed + randomized bench for boot_sram_ctrl with a behavioural SRAM and a
// shadow model of expected memory contents and address register.
module tb_boot_sram_ctrl;
  import boot_sram_ctrl_pkg::*;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int PW = 16;
  localparam int AMOD = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] pc;
  logic [DW-1:0] rom_instr, instr, sram_dq_o, sram_dq_i;
  logic [AW-1:0] sram_addr;
  logic          sram_dq_oe, sram_cen, sram_wen, sram_oen;

  boot_sram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  boot_sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .PC_W(PW), .WAIT_STATES(1), .SWITCH_DLY(2)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .pc(pc), .rom_instr(rom_instr), .instr(instr),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_oen(sram_oen)
  );

  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM.
  logic [DW-1:0] mem [0:AMOD-1];
  assign sram_dq_i = sram_oen ? 16'h0000 : mem[sram_addr];

  int            vectors = 0;
  int            miscompares = 0;
  int            wen_low_n = 0;
  int            oe_n = 0;
  int            oen_low_n = 0;
  logic          wen_prev = 1'b1;
  logic [DW-1:0] wlog [$];
  logic [DW-1:0] shadow [int];
  int            addr_list [$];

  // Expected per-cycle view after a deferred BOOT (HOLD, SWITCH x2, RUN).
  logic [2:0] boot_st_exp  [0:3] = '{3'b010, 3'b010, 3'b010, 3'b001};
  logic       boot_cen_exp [0:3] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic       boot_oe_exp  [0:3] = '{1'b1, 1'b0, 1'b0, 1'b0};

  // SRAM pin monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!sram_wen) wen_low_n++;
    if (sram_dq_oe) oe_n++;
    if (!sram_oen) oen_low_n++;
    if (!sram_cen && !sram_wen) begin
      mem[sram_addr] = sram_dq_o;
      if (wen_prev) wlog.push_back(sram_dq_o);
    end
    wen_prev = sram_wen;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_write(input logic [2:0] sel, input logic [DW-1:0] d);
    bus.wr_en = 1'b1;
    bus.wr_sel = sel;
    bus.wr_data = d;
    tick(1);
    bus.wr_en = 1'b0;
    bus.wr_sel = 3'd0;
    bus.wr_data = 16'h0000;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.status[STAT_BUSY] && (n < 20)) begin
      tick(1);
      n++;
    end
    check("idle_timeout", 32'(bus.status[STAT_BUSY]), 32'd0);
  endtask

  task automatic set_addr(input logic [AW-1:0] a);
    reg_write(SEL_ADDR_HI, 16'(a >> 16));
    reg_write(SEL_ADDR_LO, a[15:0]);
  endtask

  task automatic clr_mon();
    wen_low_n = 0;
    oe_n = 0;
    oen_low_n = 0;
    wlog.delete();
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d, x, y;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_sel = 3'd0;
    bus.wr_data = 16'h0000;
    pc = 16'h0000;
    rom_instr = 16'h1234;
    tick(3);
    rst = 1'b0;

    // Reset state.
    check("rst_status", 32'(bus.status), 32'd0);
    check("rst_addr", 32'(bus.rd_addr_q), 32'd0);
    check("rst_rdata", 32'(bus.rd_data_q), 32'd0);
    check("rst_strobes", {29'd0, sram_cen, sram_wen, sram_oen}, 32'h7);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_dq_o", 32'(sram_dq_o), 32'd0);
    check("rst_instr", 32'(instr), 32'h1234);

    // Burst write with auto-increment, writes 4 clocks apart.
    reg_write(SEL_CTRL, 16'h0001);
    reg_write(SEL_ADDR_LO, 16'h0010);
    clr_mon();
    reg_write(SEL_DATA, 16'hAAAA);
    tick(3);
    check("burst0_wen_cycles", 32'(wen_low_n), 32'd2);
    check("burst0_oe_cycles", 32'(oe_n), 32'd3);
    clr_mon();
    reg_write(SEL_DATA, 16'h5555);
    wait_idle();
    check("burst1_wen_cycles", 32'(wen_low_n), 32'd2);
    check("burst1_oe_cycles", 32'(oe_n), 32'd3);
    check("burst_mem10", 32'(mem[18'h00010]), 32'h0000AAAA);
    check("burst_mem11", 32'(mem[18'h00011]), 32'h00005555);
    check("burst_addr", 32'(bus.rd_addr_q), 32'h12);

    // Unused select codes change nothing.
    reg_write(3'd6, 16'hFFFF);
    reg_write(3'd7, 16'hFFFF);
    check("sel67_addr", 32'(bus.rd_addr_q), 32'h12);
    check("sel67_status", 32'(bus.status), 32'd0);

    // Read-back: data visible two cycles after the access starts.
    mem[18'h00010] = 16'hBEEF;
    reg_write(SEL_ADDR_LO, 16'h0010);
    clr_mon();
    reg_write(SEL_RD, 16'h0000);
    tick(2);
    check("rd_data", 32'(bus.rd_data_q), 32'hBEEF);
    check("rd_oen_cycles", 32'(oen_low_n), 32'd2);
    check("rd_busy_done", 32'(bus.status[STAT_BUSY]), 32'd0);
    check("rd_addr_inc", 32'(bus.rd_addr_q), 32'h11);

    // Random writes then random-order read-back against the shadow model.
    for (int i = 0; i < 6; i++) begin
      a = 18'($urandom);
      d = 16'($urandom);
      set_addr(a);
      reg_write(SEL_DATA, d);
      wait_idle();
      shadow[int'(a)] = d;
      addr_list.push_back(int'(a));
      check("rand_wr_mem", 32'(mem[a]), 32'(d));
      check("rand_wr_inc", 32'(bus.rd_addr_q), 32'((int'(a) + 1) % AMOD));
    end
    addr_list.shuffle();
    foreach (addr_list[i]) begin
      a = 18'(addr_list[i]);
      set_addr(a);
      reg_write(SEL_RD, 16'h0000);
      wait_idle();
      check("rand_rd_data", 32'(bus.rd_data_q), 32'(shadow[addr_list[i]]));
    end

    // Overrun: back-to-back DATA writes, second one dropped.
    x = 16'($urandom_range(1, 16'h7FFF));
    y = x ^ 16'hFFFF;
    set_addr(18'h00040);
    clr_mon();
    reg_write(SEL_DATA, x);
    reg_write(SEL_DATA, y);
    wait_idle();
    check("ovr_flag", 32'(bus.status[STAT_OVR]), 32'd1);
    check("ovr_one_strobe", 32'(wlog.size()), 32'd1);
    check("ovr_mem", 32'(mem[18'h00040]), 32'(x));
    check("ovr_addr_once", 32'(bus.rd_addr_q), 32'h41);
    reg_write(SEL_CTRL, 16'h0002);
    check("ovr_clear", 32'(bus.status), 32'd0);

    // Address wrap at the top of SRAM.
    d = 16'($urandom);
    reg_write(SEL_CTRL, 16'h0001);
    reg_write(SEL_ADDR_HI, 16'h0003);
    reg_write(SEL_ADDR_LO, 16'hFFFF);
    reg_write(SEL_DATA, d);
    wait_idle();
    check("wrap_addr", 32'(bus.rd_addr_q), 32'd0);
    check("wrap_mem", 32'(mem[18'h3FFFF]), 32'(d));

    // Reset in the second WR cycle.
    reg_write(SEL_DATA, 16'h0F0F);
    tick(1);
    check("mid_wr_wen", 32'(sram_wen), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_strobes", {29'd0, sram_cen, sram_wen, sram_oen}, 32'h7);
    check("midrst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("midrst_status", 32'(bus.status), 32'd0);
    check("midrst_instr", 32'(instr), 32'(rom_instr));
    check("midrst_addr", 32'(bus.rd_addr_q), 32'd0);

    // Deferred boot: BOOT arrives during WR.
    d = 16'($urandom);
    reg_write(SEL_CTRL, 16'h0001);
    reg_write(SEL_ADDR_LO, 16'h0020);
    bus.wr_en = 1'b1;
    bus.wr_sel = SEL_DATA;
    bus.wr_data = d;
    tick(1);
    bus.wr_sel = SEL_BOOT;
    bus.wr_data = 16'h0000;
    tick(1);
    bus.wr_en = 1'b0;
    bus.wr_sel = 3'd0;
    check("boot_wr_wen", 32'(sram_wen), 32'd0);
    check("boot_wr_status", 32'(bus.status), 32'h2);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("boot_seq_status", 32'(bus.status), 32'(boot_st_exp[k]));
      check("boot_seq_cen", 32'(sram_cen), 32'(boot_cen_exp[k]));
      check("boot_seq_dq_oe", 32'(sram_dq_oe), 32'(boot_oe_exp[k]));
      check("boot_seq_wen", 32'(sram_wen), 32'd1);
    end
    check("boot_mem", 32'(mem[18'h00020]), 32'(d));
    check("boot_addr", 32'(bus.rd_addr_q), 32'h21);

    // RUN: instruction fetch from SRAM at pc.
    for (int i = 0; i < 8; i++) begin
      pc = 16'($urandom);
      d = 16'($urandom);
      mem[{2'b00, pc}] = d;
      rom_instr = d ^ 16'h5A5A;
      #1;
      check("run_instr", 32'(instr), 32'(d));
      check("run_sram_addr", 32'(sram_addr), 32'(pc));
      check("run_oen", 32'(sram_oen), 32'd0);
      tick(1);
    end

    // RUN ignores every register write.
    reg_write(SEL_DATA, 16'h1111);
    reg_write(SEL_RD, 16'h0000);
    reg_write(SEL_ADDR_LO, 16'h0077);
    check("run_ignore_status", 32'(bus.status), 32'h1);
    check("run_ignore_addr", 32'(bus.rd_addr_q), 32'h21);
    check("run_ignore_wen", 32'(sram_wen), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
